// File: rtl/ps2_kbd_decoder.sv
// ps2_kbd_decoder: PS/2 set-2 scan-code bytes to key events with held-key repeat tracking.
// Define KBD_ASCII_EN to build the ASCII lookup; otherwise ascii is tied to 0.
module ps2_kbd_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ready,
  input  logic [7:0]       data,
  output logic             read_next,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_release,
  output logic             key_repeat,
  output logic             key_down,
  output logic [7:0]       ascii,
  output logic [CNT_W-1:0] press_count,
  output logic             seq_err
);
  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
  state_t state, nxt;
  logic fetch, is_f0, is_e0, ev, rel, ext, err, match;
  logic [7:0] held_code;
  logic held_ext, held_vld;
  assign fetch = ready && !read_next;
  assign is_f0 = data == 8'hF0;
  assign is_e0 = data == 8'hE0;
  assign match = held_vld && held_ext == ext && held_code == data;
  assign key_down = held_vld;
  always_comb begin
    nxt = state;
    ev = 1'b0;
    rel = 1'b0;
    ext = 1'b0;
    err = 1'b0;
    case (state)
      IDLE: begin
        nxt = is_e0 ? EXT : is_f0 ? BRK : IDLE;
        ev = !is_e0 && !is_f0;
      end
      EXT: begin
        nxt = is_f0 ? EXT_BRK : is_e0 ? EXT : IDLE;
        err = is_e0;
        ev = !is_e0 && !is_f0;
        ext = 1'b1;
      end
      BRK: begin
        nxt = IDLE;
        err = is_e0 || is_f0;
        ev = !err;
        rel = 1'b1;
      end
      default: begin
        nxt = IDLE;
        err = is_e0 || is_f0;
        ev = !err;
        rel = 1'b1;
        ext = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else if (fetch) state <= nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      read_next <= 1'b0;
      key_valid <= 1'b0;
      seq_err <= 1'b0;
      key_code <= '0;
      key_ext <= 1'b0;
      key_release <= 1'b0;
      key_repeat <= 1'b0;
      held_code <= '0;
      held_ext <= 1'b0;
      held_vld <= 1'b0;
      press_count <= '0;
    end else begin
      read_next <= fetch;
      key_valid <= fetch && ev;
      seq_err <= fetch && err;
      if (fetch && ev) begin
        key_code <= data;
        key_ext <= ext;
        key_release <= rel;
        key_repeat <= !rel && match;
        if (!rel && !match) begin
          held_code <= data;
          held_ext <= ext;
          held_vld <= 1'b1;
          press_count <= press_count + CNT_W'(1);
        end
        if (rel && match) held_vld <= 1'b0;
      end
    end
  end
`ifdef KBD_ASCII_EN
  function automatic logic [7:0] to_ascii(input logic [7:0] c);
    case (c)
      8'h1C: return 8'h61; 8'h32: return 8'h62; 8'h21: return 8'h63; 8'h23: return 8'h64;
      8'h24: return 8'h65; 8'h2B: return 8'h66; 8'h34: return 8'h67; 8'h33: return 8'h68;
      8'h43: return 8'h69; 8'h3B: return 8'h6A; 8'h42: return 8'h6B; 8'h4B: return 8'h6C;
      8'h3A: return 8'h6D; 8'h31: return 8'h6E; 8'h44: return 8'h6F; 8'h4D: return 8'h70;
      8'h15: return 8'h71; 8'h2D: return 8'h72; 8'h1B: return 8'h73; 8'h2C: return 8'h74;
      8'h3C: return 8'h75; 8'h2A: return 8'h76; 8'h1D: return 8'h77; 8'h22: return 8'h78;
      8'h35: return 8'h79; 8'h1A: return 8'h7A;
      8'h45: return 8'h30; 8'h16: return 8'h31; 8'h1E: return 8'h32; 8'h26: return 8'h33;
      8'h25: return 8'h34; 8'h2E: return 8'h35; 8'h36: return 8'h36; 8'h3D: return 8'h37;
      8'h3E: return 8'h38; 8'h46: return 8'h39;
      8'h29: return 8'h20; 8'h5A: return 8'h0D;
      default: return 8'h00;
    endcase
  endfunction
  always_ff @(posedge clk)
    if (rst) ascii <= '0;
    else if (fetch && ev) ascii <= ext ? 8'h00 : to_ascii(data);
`else
  assign ascii = '0;
`endif
endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// tb_ps2_kbd_decoder: directed vector table plus reset, reset/fetch collision and count-wrap sequences.
module tb_ps2_kbd_decoder;
  logic clk = 1'b0, rst, ready, read_next, key_valid, key_ext, key_release, key_repeat, key_down, seq_err;
  logic [7:0] data, key_code, ascii, press_count;
  int checks = 0, errors = 0;
  logic mon = 1'b0, prev_rn = 1'b0;

  ps2_kbd_decoder #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ready(ready), .data(data), .read_next(read_next),
    .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext), .key_release(key_release),
    .key_repeat(key_repeat), .key_down(key_down), .ascii(ascii), .press_count(press_count),
    .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic v, err, rel, ext, rep, down;
    logic [7:0] code, asc, cnt;
  } vec_t;
  vec_t tv[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_ascii(input logic [7:0] a);
`ifdef KBD_ASCII_EN
    return a;
`else
    return 8'h00;
`endif
  endfunction

  task automatic send(input logic [7:0] b);
    if (read_next) begin @(posedge clk); #1; end
    ready = 1'b1; data = b;
    @(posedge clk); #1;
    ready = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  always @(negedge clk)
    if (mon) begin
      chk("rn_gap", {31'b0, prev_rn && read_next}, 32'd0);
      prev_rn = read_next;
    end

  initial begin
    tv[0]  = '{8'h1C, 1, 0, 0, 0, 0, 1, 8'h1C, 8'h61, 8'd1};
    tv[1]  = '{8'h1C, 1, 0, 0, 0, 1, 1, 8'h1C, 8'h61, 8'd1};
    tv[2]  = '{8'h1C, 1, 0, 0, 0, 1, 1, 8'h1C, 8'h61, 8'd1};
    tv[3]  = '{8'hF0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'd1};
    tv[4]  = '{8'h1C, 1, 0, 1, 0, 0, 0, 8'h1C, 8'h61, 8'd1};
    tv[5]  = '{8'hE0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'd1};
    tv[6]  = '{8'h75, 1, 0, 0, 1, 0, 1, 8'h75, 8'h00, 8'd2};
    tv[7]  = '{8'hE0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'd2};
    tv[8]  = '{8'hF0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'd2};
    tv[9]  = '{8'h75, 1, 0, 1, 1, 0, 0, 8'h75, 8'h00, 8'd2};
    tv[10] = '{8'hF0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'd2};
    tv[11] = '{8'hF0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'd2};
    tv[12] = '{8'h1C, 1, 0, 0, 0, 0, 1, 8'h1C, 8'h61, 8'd3};
    tv[13] = '{8'hF0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'd3};
    tv[14] = '{8'h29, 1, 0, 1, 0, 0, 1, 8'h29, 8'h20, 8'd3};
    tv[15] = '{8'hE0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'd3};
    tv[16] = '{8'hE0, 0, 1, 0, 0, 0, 1, 8'h00, 8'h00, 8'd3};
    tv[17] = '{8'h1C, 1, 0, 0, 1, 0, 1, 8'h1C, 8'h00, 8'd4};
    tv[18] = '{8'h45, 1, 0, 0, 0, 0, 1, 8'h45, 8'h30, 8'd5};
    tv[19] = '{8'h5A, 1, 0, 0, 0, 0, 1, 8'h5A, 8'h0D, 8'd6};
    tv[20] = '{8'hE0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'd6};
    tv[21] = '{8'hF0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'd6};
    tv[22] = '{8'hE0, 0, 1, 0, 0, 0, 1, 8'h00, 8'h00, 8'd6};
    tv[23] = '{8'h5A, 1, 0, 0, 0, 1, 1, 8'h5A, 8'h0D, 8'd6};

    rst = 1'b1; ready = 1'b0; data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_outs", {read_next, key_valid, key_ext, key_release, key_repeat, key_down, seq_err,
                     key_code, ascii, press_count}, 32'd0);

    for (int i = 0; i < 24; i++) begin
      send(tv[i].b);
      chk($sformatf("v%0d_rn", i), {31'b0, read_next}, 32'd1);
      chk($sformatf("v%0d_valid", i), {31'b0, key_valid}, {31'b0, tv[i].v});
      chk($sformatf("v%0d_err", i), {31'b0, seq_err}, {31'b0, tv[i].err});
      chk($sformatf("v%0d_down", i), {31'b0, key_down}, {31'b0, tv[i].down});
      chk($sformatf("v%0d_cnt", i), {24'b0, press_count}, {24'b0, tv[i].cnt});
      if (tv[i].v) begin
        chk($sformatf("v%0d_code", i), {24'b0, key_code}, {24'b0, tv[i].code});
        chk($sformatf("v%0d_ext", i), {31'b0, key_ext}, {31'b0, tv[i].ext});
        chk($sformatf("v%0d_rel", i), {31'b0, key_release}, {31'b0, tv[i].rel});
        chk($sformatf("v%0d_rep", i), {31'b0, key_repeat}, {31'b0, tv[i].rep});
        chk($sformatf("v%0d_ascii", i), {24'b0, ascii}, {24'b0, exp_ascii(tv[i].asc)});
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_pulse_end", i), {30'b0, key_valid, seq_err}, 32'd0);
    end

    send(8'hF0);
    pulse_rst();
    chk("midrst_outs", {read_next, key_valid, key_ext, key_release, key_repeat, key_down, seq_err,
                        key_code, ascii, press_count}, 32'd0);
    send(8'h1C);
    chk("midrst_valid", {31'b0, key_valid}, 32'd1);
    chk("midrst_rel", {31'b0, key_release}, 32'd0);
    chk("midrst_cnt", {24'b0, press_count}, 32'd1);
    chk("midrst_down", {31'b0, key_down}, 32'd1);

    if (read_next) begin @(posedge clk); #1; end
    rst = 1'b1; ready = 1'b1; data = 8'h29;
    @(posedge clk); #1;
    rst = 1'b0; ready = 1'b0;
    chk("rstfetch_rn", {31'b0, read_next}, 32'd0);
    chk("rstfetch_valid", {31'b0, key_valid}, 32'd0);
    chk("rstfetch_cnt", {24'b0, press_count}, 32'd0);

    mon = 1'b1;
    ready = 1'b1;
    for (int p = 0; p < 256; p++) begin
      for (int k = 0; k < 3; k++) begin
        int n;
        data = (k == 1) ? 8'hF0 : 8'h1C;
        n = 0;
        do begin
          @(posedge clk); #1;
          n++;
        end while (!read_next && n < 4);
        if (!read_next) chk("pop_timeout", 32'd0, 32'd1);
      end
      if (p == 0) chk("wrap_first", {24'b0, press_count}, 32'd1);
      if (p == 254) chk("wrap_255", {24'b0, press_count}, 32'd255);
    end
    ready = 1'b0;
    @(posedge clk); #1;
    mon = 1'b0;
    chk("wrap_cnt", {24'b0, press_count}, 32'd0);
    chk("wrap_down", {31'b0, key_down}, 32'd0);
    chk("wrap_last_rel", {31'b0, key_release}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
